alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU interface. It accepts one decoded-instruction packet at a time over a valid/ready handshake.
- It translates opcode/funct3/funct7 into the 4-bit ALU control code and drives the ALU operands from registers.
- It waits the required number of cycles, then captures the ALU result and zero flag and resolves branches.
- It returns the result over a second valid/ready handshake. It sits between the register-read stage and writeback/PC-update.

Parameters:
- MUL_WAIT, 2: EXEC cycles held for a multiply. Legal range 1..15.
- XLEN, 32: operand/result width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction packet valid
- in_ready  out  1  block can accept a packet
- opcode  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- rs1_data  in  32  source operand 1
- rs2_data  in  32  source operand 2
- imm  in  32  sign-extended immediate
- alu_in1  out  32  ALU operand 1 (registered)
- alu_in2  out  32  ALU operand 2 (registered)
- alu_ctrl  out  4  ALU function code (registered)
- alu_result  in  32  combinational ALU result
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  result packet valid
- out_ready  in  1  consumer accepts result
- result  out  32  captured ALU result
- branch_taken  out  1  branch condition true
- illegal  out  1  unsupported instruction

Behaviour:
- Reset:
  - State goes to IDLE. alu_in1, alu_in2, alu_ctrl, result, out_valid, branch_taken and illegal all reset to 0.
  - Reset takes effect immediately on rst_n falling, including mid-EXEC or mid-DONE. Any in-flight packet is discarded.
- ALU function codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0100, SRL 0101, MUL 0110, XOR 0111, SLT 1000.
- Decode for R-type, opcode 0110011; operand 2 = {27'b0, rs2_data[4:0]} for shifts, else rs2_data:
  - funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND; 011 is illegal.
  - funct7 0100000: funct3 000 is SUB; anything else is illegal.
  - funct7 0000001: funct3 000 is MUL; anything else is illegal.
  - Any other funct7 is illegal.
- Decode for I-type, opcode 0010011; operand 2 = imm, or {27'b0, imm[4:0]} for shifts:
  - funct3 000 ADD, 001 SLL, 010 SLT, 100 XOR, 110 OR, 111 AND.
  - funct3 101 is SRL if imm[11:5]=0000000, else illegal (SRAI is not supported).
  - funct3 011 is illegal.
- Decode for branch, opcode 1100011; operand 2 = rs2_data:
  - BEQ (000) and BNE (001) use SUB.
  - BLT (100) uses SLT. The ALU compare is unsigned.
  - Any other funct3 is illegal.
- Any other opcode is illegal.
- alu_in1 = rs1_data in all legal cases.
- FSM IDLE -> EXEC -> DONE:
  - IDLE: in_ready=1. On in_valid&&in_ready, register alu_in1, alu_in2 and alu_ctrl, load the wait counter (MUL_WAIT for MUL, else 1), and go to EXEC. An illegal packet instead goes straight to DONE with illegal=1, result=0 and branch_taken=0. alu_ctrl/alu_in* hold their last values in that case.
  - EXEC: in_ready=0 and ALU inputs are held stable. The counter decrements each cycle. In the cycle the counter equals 1, the block captures result<=alu_result, computes branch_taken, sets out_valid<=1 and goes to DONE.
  - branch_taken is computed as: BEQ alu_zero; BNE !alu_zero; BLT alu_result==1; non-branch 0.
  - DONE: out_valid=1. result, branch_taken and illegal are held until out_ready. On out_valid&&out_ready, out_valid<=0 and the FSM goes to IDLE. illegal clears on that transfer.
- Latency, with acceptance at edge 0: non-MUL gives out_valid from edge 2; MUL gives out_valid from edge 1+MUL_WAIT; illegal gives out_valid from edge 1.
- Throughput: at most one packet in flight. in_valid is ignored outside IDLE.
- alu_ctrl, alu_in1 and alu_in2 retain their values after DONE until the next accept.

Test Plan:
- R-type ADD: rs1=5, rs2=7, opcode 0110011, f3 000, f7 0 -> alu_ctrl=0010; out_valid at edge 2; result=12; branch_taken=0; illegal=0.
- R-type MUL with MUL_WAIT=3: rs1=6, rs2=7 -> alu_ctrl=0110; alu_in* held 3 cycles; out_valid at edge 4; result=42.
- Branches:
  - BEQ rs1=rs2=9 -> alu_ctrl=0100, branch_taken=1.
  - BNE with same operands -> branch_taken=0.
  - BLT rs1=3, rs2=8 -> alu_ctrl=1000, branch_taken=1.
- Illegal: opcode 0010011 with f3 011 -> out_valid at edge 1, illegal=1, result=0. Also SRAI (imm[11:5]=0100000) -> illegal=1.
- Backpressure: out_ready low 5 cycles after an XORI with rs1=FF, imm=0F -> result=F0 stable throughout; in_ready=0; a second in_valid pulse is ignored; the packet is accepted only after the handshake completes.
- Reset mid-EXEC of a MUL: rst_n low -> all outputs 0 at once; after release, in_ready=1 and the next ADD completes normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the ALU: decodes one instruction packet, drives registered ALU operands,
// waits out the execute latency, then returns the captured result and branch decision.
module alu_issue_ctrl #(
  parameter int unsigned MUL_WAIT = 2,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSll = 4'b0011;
  localparam logic [3:0] CtrlSub = 4'b0100;
  localparam logic [3:0] CtrlSrl = 4'b0101;
  localparam logic [3:0] CtrlMul = 4'b0110;
  localparam logic [3:0] CtrlXor = 4'b0111;
  localparam logic [3:0] CtrlSlt = 4'b1000;

  localparam logic [6:0] OpR = 7'b0110011;
  localparam logic [6:0] OpI = 7'b0010011;
  localparam logic [6:0] OpB = 7'b1100011;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
  typedef enum logic [1:0] {BrNone, BrEq, BrNe, BrLt} br_e;

  state_e          state_q, state_d;
  br_e             br_q, br_d, dec_br;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d, result_q, result_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d, dec_ctrl;
  logic [XLEN-1:0] dec_op2;
  logic            dec_ill, dec_mul;
  logic            out_valid_q, out_valid_d, branch_q, branch_d, illegal_q, illegal_d;

  always_comb begin
    dec_ctrl = CtrlAdd;
    dec_op2  = rs2_data;
    dec_ill  = 1'b0;
    dec_mul  = 1'b0;
    dec_br   = BrNone;
    case (opcode)
      OpR: begin
        case (funct7)
          7'b0000000: begin
            unique case (funct3)
              3'b000: dec_ctrl = CtrlAdd;
              3'b001: begin dec_ctrl = CtrlSll; dec_op2 = {27'b0, rs2_data[4:0]}; end
              3'b010: dec_ctrl = CtrlSlt;
              3'b011: dec_ill  = 1'b1;
              3'b100: dec_ctrl = CtrlXor;
              3'b101: begin dec_ctrl = CtrlSrl; dec_op2 = {27'b0, rs2_data[4:0]}; end
              3'b110: dec_ctrl = CtrlOr;
              3'b111: dec_ctrl = CtrlAnd;
            endcase
          end
          7'b0100000: if (funct3 == 3'b000) dec_ctrl = CtrlSub; else dec_ill = 1'b1;
          7'b0000001: begin
            if (funct3 == 3'b000) begin
              dec_ctrl = CtrlMul;
              dec_mul  = 1'b1;
            end else begin
              dec_ill = 1'b1;
            end
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OpI: begin
        dec_op2 = imm;
        unique case (funct3)
          3'b000: dec_ctrl = CtrlAdd;
          3'b001: begin dec_ctrl = CtrlSll; dec_op2 = {27'b0, imm[4:0]}; end
          3'b010: dec_ctrl = CtrlSlt;
          3'b011: dec_ill  = 1'b1;
          3'b100: dec_ctrl = CtrlXor;
          3'b101: begin
            // Only the logical right shift is supported; SRAI encodings are rejected.
            if (imm[11:5] == 7'b0000000) begin
              dec_ctrl = CtrlSrl;
              dec_op2  = {27'b0, imm[4:0]};
            end else begin
              dec_ill = 1'b1;
            end
          end
          3'b110: dec_ctrl = CtrlOr;
          3'b111: dec_ctrl = CtrlAnd;
        endcase
      end
      OpB: begin
        case (funct3)
          3'b000:  begin dec_ctrl = CtrlSub; dec_br = BrEq; end
          3'b001:  begin dec_ctrl = CtrlSub; dec_br = BrNe; end
          3'b100:  begin dec_ctrl = CtrlSlt; dec_br = BrLt; end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = dec_ill ? StDone : StExec;
      StExec: if (cnt_q == 4'd1) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    alu_ctrl_d  = alu_ctrl_q;
    cnt_d       = cnt_q;
    br_d        = br_q;
    result_d    = result_q;
    branch_d    = branch_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (dec_ill) begin
            illegal_d   = 1'b1;
            result_d    = '0;
            branch_d    = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            alu_in1_d  = rs1_data;
            alu_in2_d  = dec_op2;
            alu_ctrl_d = dec_ctrl;
            cnt_d      = dec_mul ? 4'(MUL_WAIT) : 4'd1;
            br_d       = dec_br;
          end
        end
      end
      StExec: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          result_d    = alu_result;
          out_valid_d = 1'b1;
          unique case (br_q)
            BrEq:    branch_d = alu_zero;
            BrNe:    branch_d = !alu_zero;
            BrLt:    branch_d = (alu_result == 32'd1);
            default: branch_d = 1'b0;
          endcase
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          illegal_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_ctrl_q  <= '0;
      cnt_q       <= '0;
      br_q        <= BrNone;
      result_q    <= '0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_ctrl_q  <= alu_ctrl_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      result_q    <= result_d;
      branch_q    <= branch_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign alu_in1      = alu_in1_q;
  assign alu_in2      = alu_in2_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign result       = result_q;
  assign branch_taken = branch_q;
  assign illegal      = illegal_q;
  assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with MUL_WAIT=3 and a behavioural ALU on the operand bus.
module tb_alu_issue_ctrl;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, imm, alu_in1, alu_in2, alu_result, result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, branch_taken, illegal;
  int          n_checks, n_errors;

  alu_issue_ctrl #(.MUL_WAIT(3), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unsigned-compare ALU, as seen by the controller.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_in1 & alu_in2;
      4'b0001: alu_result = alu_in1 | alu_in2;
      4'b0010: alu_result = alu_in1 + alu_in2;
      4'b0011: alu_result = alu_in1 << alu_in2[4:0];
      4'b0100: alu_result = alu_in1 - alu_in2;
      4'b0101: alu_result = alu_in1 >> alu_in2[4:0];
      4'b0110: alu_result = alu_in1 * alu_in2;
      4'b0111: alu_result = alu_in1 ^ alu_in2;
      4'b1000: alu_result = {31'b0, alu_in1 < alu_in2};
      default: alu_result = 32'b0;
    endcase
    alu_zero = (alu_result == 32'b0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    opcode = op; funct3 = f3; funct7 = f7; rs1_data = a; rs2_data = b; imm = im;
  endtask

  task automatic run_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input int exp_lat, input logic [3:0] exp_ctrl,
                         input logic [31:0] exp_in2, input logic [31:0] exp_res,
                         input logic exp_br, input logic exp_ill);
    int edges;
    @(negedge clk);
    check_eq({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    drive(op, f3, f7, a, b, im);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check_eq({tag, ":latency"}, 32'(edges + 1), 32'(exp_lat));
    check_eq({tag, ":result"}, result, exp_res);
    check_eq({tag, ":branch"}, 32'(branch_taken), 32'(exp_br));
    check_eq({tag, ":illegal"}, 32'(illegal), 32'(exp_ill));
    if (!exp_ill) begin
      check_eq({tag, ":ctrl"}, 32'(alu_ctrl), 32'(exp_ctrl));
      check_eq({tag, ":in1"}, alu_in1, a);
      check_eq({tag, ":in2"}, alu_in2, exp_in2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, ":valid_clr"}, 32'(out_valid), 32'd0);
    check_eq({tag, ":illegal_clr"}, 32'(illegal), 32'd0);
    check_eq({tag, ":idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int edges;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check_eq("rst:out_valid", 32'(out_valid), 32'd0);
    check_eq("rst:ctrl", 32'(alu_ctrl), 32'd0);
    check_eq("rst:result", result, 32'd0);
    check_eq("rst:illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;

    run_txn("add", 7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0,
            2, 4'b0010, 32'd7, 32'd12, 1'b0, 1'b0);
    run_txn("sll", 7'b0110011, 3'b001, 7'b0000000, 32'd3, 32'h21, 32'd0,
            2, 4'b0011, 32'd1, 32'd6, 1'b0, 1'b0);
    run_txn("mul", 7'b0110011, 3'b000, 7'b0000001, 32'd6, 32'd7, 32'd0,
            4, 4'b0110, 32'd7, 32'd42, 1'b0, 1'b0);
    run_txn("beq", 7'b1100011, 3'b000, 7'b0000000, 32'd9, 32'd9, 32'd0,
            2, 4'b0100, 32'd9, 32'd0, 1'b1, 1'b0);
    run_txn("bne", 7'b1100011, 3'b001, 7'b0000000, 32'd9, 32'd9, 32'd0,
            2, 4'b0100, 32'd9, 32'd0, 1'b0, 1'b0);
    run_txn("blt", 7'b1100011, 3'b100, 7'b0000000, 32'd3, 32'd8, 32'd0,
            2, 4'b1000, 32'd8, 32'd1, 1'b1, 1'b0);
    run_txn("blt_nt", 7'b1100011, 3'b100, 7'b0000000, 32'd8, 32'd3, 32'd0,
            2, 4'b1000, 32'd3, 32'd0, 1'b0, 1'b0);
    run_txn("ill_f3", 7'b0010011, 3'b011, 7'b0000000, 32'd1, 32'd2, 32'd3,
            1, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1);
    check_eq("ill_f3:ctrl_hold", 32'(alu_ctrl), 32'h8);
    run_txn("srai", 7'b0010011, 3'b101, 7'b0000000, 32'h80, 32'd0, 32'h405,
            1, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1);

    // Backpressure: hold out_ready low and pulse a second packet that must be ignored.
    @(negedge clk);
    drive(7'b0010011, 3'b100, 7'b0000000, 32'hFF, 32'd0, 32'h0F);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check_eq("bp:latency", 32'(edges + 1), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp:result", result, 32'hF0);
      check_eq("bp:in_ready", 32'(in_ready), 32'd0);
      check_eq("bp:valid", 32'(out_valid), 32'd1);
      if (i == 1) drive(7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0);
      in_valid = (i == 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp:valid_clr", 32'(out_valid), 32'd0);
    check_eq("bp:idle", 32'(in_ready), 32'd1);
    check_eq("bp:ctrl_kept", 32'(alu_ctrl), 32'h7);
    check_eq("bp:in1_kept", alu_in1, 32'hFF);
    @(negedge clk);
    check_eq("bp:no_accept", 32'(in_ready), 32'd1);

    // Reset in the middle of a multiply.
    drive(7'b0110011, 3'b000, 7'b0000001, 32'd6, 32'd7, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("rmid:exec", 32'(in_ready), 32'd0);
    check_eq("rmid:ctrl", 32'(alu_ctrl), 32'h6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rmid:in1", alu_in1, 32'd0);
    check_eq("rmid:in2", alu_in2, 32'd0);
    check_eq("rmid:ctrl0", 32'(alu_ctrl), 32'd0);
    check_eq("rmid:result", result, 32'd0);
    check_eq("rmid:valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rmid:ready", 32'(in_ready), 32'd1);
    run_txn("add2", 7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0,
            2, 4'b0010, 32'd7, 32'd12, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
